// File: rtl/coin_change_dispenser.sv
// Coin-return dispenser: pays a change amount as timed 10c/5c pulses on the
// 2-bit coin bus, using 10c coins first and 5c coins for the rest.
module coin_change_dispenser #(
    parameter int AMOUNT_W     = 4,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic [AMOUNT_W-1:0] amount,
    input  logic                empty10,
    input  logic                empty5,
    output logic                ready,
    output logic [1:0]          coins,
    output logic [AMOUNT_W-1:0] remaining,
    output logic                done,
    output logic                fault
);

    localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          coins_q, coins_d;
    logic [AMOUNT_W-1:0] rem_q, rem_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rem_ge2;

    assign rem_ge2 = |rem_q[AMOUNT_W-1:1];

    always_comb begin
        state_d = state_q;
        coins_d = coins_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        fault_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    rem_d   = amount;
                    state_d = S_SELECT;
                end
            end

            // Tube sensors are looked at only here, once per coin.
            S_SELECT: begin
                cnt_d = '0;
                if (rem_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (rem_ge2 && !empty10) begin
                    coins_d = COIN_10;
                    state_d = S_PULSE;
                end else if (!empty5) begin
                    coins_d = COIN_5;
                    state_d = S_PULSE;
                end else begin
                    fault_d = 1'b1;
                    state_d = S_IDLE;
                end
            end

            // Coin codes 01/10 equal the coin value in 5c units.
            S_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    rem_d   = rem_q - AMOUNT_W'(coins_q);
                    coins_d = COIN_NONE;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SELECT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DONE: begin
                rem_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                coins_d = COIN_NONE;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            coins_q <= COIN_NONE;
            rem_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            coins_q <= coins_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign coins     = coins_q;
    assign remaining = rem_q;
    assign done      = done_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser with PULSE_CYCLES=4, GAP_CYCLES=2.
module tb_coin_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic [3:0] amount;
    logic       empty10;
    logic       empty5;
    logic       ready;
    logic [1:0] coins;
    logic [3:0] remaining;
    logic       done;
    logic       fault;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    coin_change_dispenser #(
        .AMOUNT_W    (4),
        .PULSE_CYCLES(4),
        .GAP_CYCLES  (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .amount   (amount),
        .empty10  (empty10),
        .empty5   (empty5),
        .ready    (ready),
        .coins    (coins),
        .remaining(remaining),
        .done     (done),
        .fault    (fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] c, input logic [3:0] r,
                           input logic d, input logic f, input logic rdy);
        chk({tag, ".coins"},     32'(coins),     32'(c));
        chk({tag, ".remaining"}, 32'(remaining), 32'(r));
        chk({tag, ".done"},      32'(done),      32'(d));
        chk({tag, ".fault"},     32'(fault),     32'(f));
        chk({tag, ".ready"},     32'(ready),     32'(rdy));
    endtask

    // n consecutive cycles, each sampled on the falling edge
    task automatic cyc(input int n, input logic [1:0] c, input logic [3:0] r,
                       input logic d, input logic f, input logic rdy, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_all(tag, c, r, d, f, rdy);
        end
    endtask

    initial begin
        reset   = 1'b0;
        req     = 1'b0;
        amount  = 4'd0;
        empty10 = 1'b0;
        empty5  = 1'b0;
        #3;
        chk_all("reset", 2'b00, 4'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // amount=3, both tubes full: 10c then 5c
        req = 1'b1; amount = 4'd3;
        cyc(1, 2'b00, 4'd3, 0, 0, 0, "t1.sel1");
        req = 1'b0;
        cyc(4, 2'b10, 4'd3, 0, 0, 0, "t1.pulse10");
        cyc(2, 2'b00, 4'd1, 0, 0, 0, "t1.gap1");
        cyc(1, 2'b00, 4'd1, 0, 0, 0, "t1.sel2");
        cyc(4, 2'b01, 4'd1, 0, 0, 0, "t1.pulse5");
        cyc(2, 2'b00, 4'd0, 0, 0, 0, "t1.gap2");
        cyc(1, 2'b00, 4'd0, 0, 0, 0, "t1.sel3");
        cyc(1, 2'b00, 4'd0, 1, 0, 0, "t1.done");
        cyc(1, 2'b00, 4'd0, 0, 0, 1, "t1.idle");

        // amount=2, 10c tube empty: two 5c coins
        req = 1'b1; amount = 4'd2; empty10 = 1'b1;
        cyc(1, 2'b00, 4'd2, 0, 0, 0, "t2.sel1");
        req = 1'b0;
        cyc(4, 2'b01, 4'd2, 0, 0, 0, "t2.pulse1");
        cyc(2, 2'b00, 4'd1, 0, 0, 0, "t2.gap1");
        cyc(1, 2'b00, 4'd1, 0, 0, 0, "t2.sel2");
        cyc(4, 2'b01, 4'd1, 0, 0, 0, "t2.pulse2");
        cyc(2, 2'b00, 4'd0, 0, 0, 0, "t2.gap2");
        cyc(1, 2'b00, 4'd0, 0, 0, 0, "t2.sel3");
        cyc(1, 2'b00, 4'd0, 1, 0, 0, "t2.done");
        cyc(1, 2'b00, 4'd0, 0, 0, 1, "t2.idle");

        // amount=1, 5c tube empty: fault, balance kept
        req = 1'b1; amount = 4'd1; empty10 = 1'b0; empty5 = 1'b1;
        cyc(1, 2'b00, 4'd1, 0, 0, 0, "t3.sel");
        req = 1'b0;
        cyc(1, 2'b00, 4'd1, 0, 1, 1, "t3.fault");
        cyc(2, 2'b00, 4'd1, 0, 0, 1, "t3.idle");

        // amount=0: done two cycles after the accept cycle, no coins
        req = 1'b1; amount = 4'd0; empty5 = 1'b0;
        cyc(1, 2'b00, 4'd0, 0, 0, 0, "t4.sel");
        req = 1'b0;
        cyc(1, 2'b00, 4'd0, 1, 0, 0, "t4.done");
        cyc(1, 2'b00, 4'd0, 0, 0, 1, "t4.idle");

        // async reset in the 2nd cycle of a 10c pulse
        req = 1'b1; amount = 4'd2;
        cyc(1, 2'b00, 4'd2, 0, 0, 0, "t5.sel");
        req = 1'b0;
        cyc(1, 2'b10, 4'd2, 0, 0, 0, "t5.pulse1");
        @(posedge clk);
        #2;
        chk("t5.pulse2.coins", 32'(coins), 32'(2'b10));
        reset = 1'b0;
        #1;
        chk_all("t5.async", 2'b00, 4'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        cyc(1, 2'b00, 4'd0, 0, 0, 1, "t5.after");

        // req held, amount changed mid-payout: ignored until the next accept
        req = 1'b1; amount = 4'd2;
        cyc(1, 2'b00, 4'd2, 0, 0, 0, "t6.a.sel");
        amount = 4'd5;
        cyc(4, 2'b10, 4'd2, 0, 0, 0, "t6.a.pulse");
        cyc(2, 2'b00, 4'd0, 0, 0, 0, "t6.a.gap");
        cyc(1, 2'b00, 4'd0, 0, 0, 0, "t6.a.sel2");
        cyc(1, 2'b00, 4'd0, 1, 0, 0, "t6.a.done");
        cyc(1, 2'b00, 4'd0, 0, 0, 1, "t6.a.idle");
        cyc(1, 2'b00, 4'd5, 0, 0, 0, "t6.b.sel1");
        req = 1'b0;
        cyc(4, 2'b10, 4'd5, 0, 0, 0, "t6.b.pulse1");
        cyc(2, 2'b00, 4'd3, 0, 0, 0, "t6.b.gap1");
        cyc(1, 2'b00, 4'd3, 0, 0, 0, "t6.b.sel2");
        cyc(4, 2'b10, 4'd3, 0, 0, 0, "t6.b.pulse2");
        cyc(2, 2'b00, 4'd1, 0, 0, 0, "t6.b.gap2");
        cyc(1, 2'b00, 4'd1, 0, 0, 0, "t6.b.sel3");
        cyc(4, 2'b01, 4'd1, 0, 0, 0, "t6.b.pulse3");
        cyc(2, 2'b00, 4'd0, 0, 0, 0, "t6.b.gap3");
        cyc(1, 2'b00, 4'd0, 0, 0, 0, "t6.b.sel4");
        cyc(1, 2'b00, 4'd0, 1, 0, 0, "t6.b.done");
        cyc(2, 2'b00, 4'd0, 0, 0, 1, "t6.b.idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
